// File: rtl/auth_cmd_tx_pkg.sv
// Shared constants and FSM encoding for the rider-authorization command transmitter.
package auth_pkg;

  localparam logic [7:0] AUTH_CMD_G = 8'h47;
  localparam logic [7:0] AUTH_CMD_S = 8'h53;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } auth_tx_state_t;

endpackage

// File: rtl/auth_cmd_tx_if.sv
// Command/status bundle of auth_cmd_tx; also carries the FSM state for observation.
interface auth_cmd_tx_if;
  import auth_pkg::*;

  // go_req/stop_req are one-cycle strobes with no ready: every high cycle is a request,
  // always accepted, coalescing into a single-deep pending flag (latest request wins).
  logic           go_req;
  logic           stop_req;
  logic           TX;
  logic           busy;
  logic           tx_done;
  logic           link_active;
  auth_tx_state_t state;

  modport master (
    output go_req, stop_req,
    input  TX, busy, tx_done, link_active, state
  );

  modport slave (
    input  go_req, stop_req,
    output TX, busy, tx_done, link_active, state
  );

endinterface

// File: rtl/auth_cmd_tx_uart_tx.sv
// 8N1 UART serializer: one trmt pulse sends start, 8 data bits LSB first, stop.
module uart_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

  logic [11:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [8:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        active_q, active_d;
  logic        baud_end;

  assign baud_end = (baud_q == BAUD_LAST);
  assign tx_done  = active_q && baud_end && (bit_q == 4'd9);
  assign TX       = tx_q;

  always_comb begin
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    active_d = active_q;
    if (trmt) begin
      // Stop bit rides in the shift register behind the data bits.
      tx_d     = 1'b0;
      shift_d  = {1'b1, tx_data};
      baud_d   = 12'd0;
      bit_d    = 4'd0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (baud_end) begin
        baud_d = 12'd0;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[8:1]};
          bit_d   = bit_q + 4'd1;
        end
      end else begin
        baud_d = baud_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q   <= 12'd0;
      bit_q    <= 4'd0;
      shift_q  <= 9'h1ff;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
    end else begin
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/auth_cmd_tx.sv
// Go/stop command arbiter and link tracker feeding uart_tx.
// Optional keep-alive 'G' generator enabled by defining AUTH_TX_HEARTBEAT_EN.
module auth_cmd_tx
  import auth_pkg::*;
#(
  parameter int BAUD_DIV  = 2604,
  parameter int HB_PERIOD = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  auth_cmd_tx_if.slave       bus
);

  if (BAUD_DIV < 4 || BAUD_DIV > 4095 || HB_PERIOD < 2 || HB_PERIOD > (1 << 26))
  begin : g_param_check
    $error("auth_cmd_tx: BAUD_DIV or HB_PERIOD out of range");
  end

  auth_tx_state_t state_q, state_d;
  logic [7:0]     cmd_q, cmd_d;
  logic           go_pend_q, go_pend_d;
  logic           stop_pend_q, stop_pend_d;
  logic           link_q, link_d;
  logic           trmt;
  logic           uart_done;
  logic           tx_w;
  logic           hb_fire;

`ifdef AUTH_TX_HEARTBEAT_EN
  localparam logic [25:0] HB_LAST = 26'(HB_PERIOD - 1);
  logic [25:0] hb_q, hb_d;
  logic        hb_run;

  assign hb_run  = link_q && (state_q == IDLE) && !go_pend_q && !stop_pend_q;
  assign hb_fire = hb_run && (hb_q == HB_LAST);

  always_comb begin
    hb_d = hb_q;
    if (state_q == LOAD || !link_q) hb_d = 26'd0;
    else if (hb_run)                hb_d = hb_q + 26'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) hb_q <= 26'd0;
    else     hb_q <= hb_d;
  end
`else
  assign hb_fire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    link_d      = link_q;
    go_pend_d   = go_pend_q;
    stop_pend_d = stop_pend_q;
    trmt        = 1'b0;
    case (state_q)
      IDLE: begin
        if (stop_pend_q) begin
          cmd_d       = AUTH_CMD_S;
          stop_pend_d = 1'b0;
          state_d     = LOAD;
        end else if (go_pend_q) begin
          cmd_d     = AUTH_CMD_G;
          go_pend_d = 1'b0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        trmt    = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (uart_done) begin
          state_d = IDLE;
          link_d  = (cmd_q == AUTH_CMD_G);
        end
      end
      default: state_d = IDLE;
    endcase
    // New requests override the clear above, so a request on the selection cycle is kept.
    if (bus.stop_req) begin
      stop_pend_d = 1'b1;
      go_pend_d   = 1'b0;
    end else if (bus.go_req || hb_fire) begin
      go_pend_d   = 1'b1;
      stop_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= 8'h00;
      link_q      <= 1'b0;
      go_pend_q   <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      link_q      <= link_d;
      go_pend_q   <= go_pend_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart_tx (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt),
    .tx_data (cmd_q),
    .TX      (tx_w),
    .tx_done (uart_done)
  );

  assign bus.TX          = tx_w;
  assign bus.tx_done     = uart_done;
  assign bus.busy        = (state_q != IDLE);
  assign bus.link_active = link_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_auth_cmd_tx.sv
// Bench for auth_cmd_tx: frame-level reference model feeds an expected queue,
// a UART-decoding monitor pops and compares each frame seen on TX.
module tb_auth_cmd_tx;
  import auth_pkg::*;

  localparam int BAUD  = 4;
  localparam int HB    = 100;
  localparam int FRAME = 10 * BAUD;
  localparam int P_NONE = 0, P_G = 1, P_S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  auth_cmd_tx_if bus ();

  auth_cmd_tx #(.BAUD_DIV(BAUD), .HB_PERIOD(HB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: {start cycle, byte} of every frame the link should carry
  logic [39:0] exp_q[$];
  int m_pend, m_sel_ok, m_hb;
  bit m_link, m_link_after;

  task automatic model_reset();
    m_pend = P_NONE;
    m_sel_ok = 0;
    m_hb = 0;
    m_link = 1'b0;
    m_link_after = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input int c, input bit go, input bit stop);
    bit fire = 1'b0;
    logic [7:0] b;
    if (c >= m_sel_ok) m_link = m_link_after;
`ifdef AUTH_TX_HEARTBEAT_EN
    if (!m_link) m_hb = 0;
    else if (c >= m_sel_ok && m_pend == P_NONE) begin
      if (m_hb == HB - 1) fire = 1'b1;
      else m_hb++;
    end
`endif
    if (c >= m_sel_ok && m_pend != P_NONE) begin
      b = (m_pend == P_G) ? AUTH_CMD_G : AUTH_CMD_S;
      exp_q.push_back({32'(c + 2), b});
      m_sel_ok = c + 2 + FRAME;
      m_link_after = (m_pend == P_G);
      m_pend = P_NONE;
      m_hb = 0;
    end
    if (stop) m_pend = P_S;
    else if (go || fire) m_pend = P_G;
  endtask

  // driver tasks
  task automatic drive(input bit r, input bit go, input bit stop);
    @(posedge clk);
    #1;
    rst = r;
    bus.go_req = go;
    bus.stop_req = stop;
    if (r) model_reset();
    else model_step(cyc, go, stop);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  // monitor / scoreboard
  bit         mon_en = 1'b0;
  bit         in_frame = 1'b0;
  bit         have_exp;
  int         st, off, exp_start;
  logic [7:0] exp_byte, rx;
  int         frames_seen = 0, unexpected = 0, spurious = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (bus.tx_done !== 1'b0) spurious++;
        if (bus.TX === 1'b0) begin
          logic [39:0] e;
          in_frame = 1'b1;
          st = cyc;
          frames_seen++;
          if (exp_q.size() == 0) begin
            have_exp = 1'b0;
            unexpected++;
            $display("FAIL frame_expected: got frame at cycle %0d expected none", cyc);
          end else begin
            e = exp_q.pop_front();
            have_exp = 1'b1;
            exp_start = int'(e[39:8]);
            exp_byte = e[7:0];
            check("start_cycle", st, exp_start);
          end
          check("busy_in_frame", bus.busy, 1);
        end
      end else begin
        off = cyc - st;
        if (off < FRAME - 1 && bus.tx_done !== 1'b0) spurious++;
        if (off == 2) check("start_bit", bus.TX, 0);
        if (off >= 6 && off <= 34 && (off - 2) % 4 == 0) rx[(off - 6) / 4] = bus.TX;
        if (off == 38) check("stop_bit", bus.TX, 1);
        if (off == FRAME - 1) begin
          check("tx_done_pulse", bus.tx_done, 1);
          if (have_exp) check("frame_byte", rx, exp_byte);
        end
        if (off == FRAME) begin
          if (have_exp) check("link_after_frame", bus.link_active, exp_byte == AUTH_CMD_G);
          check("busy_after_frame", bus.busy, 0);
          in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int bad;
  int f0;
  int n;

  initial begin
    bus.go_req = 1'b0;
    bus.stop_req = 1'b0;
    model_reset();

    // reset state and quiet line
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_tx", bus.TX, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_tx_done", bus.tx_done, 0);
    check("rst_link", bus.link_active, 0);
    mon_en = 1'b1;
    bad = 0;
    repeat (50) begin
      drive(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (bus.TX !== 1'b1) bad++;
    end
    check("idle_tx_high", bad, 0);

    // single 'G'
    drive(1'b0, 1'b1, 1'b0);
    idle(45);
    @(negedge clk);
    check("link_after_go", bus.link_active, 1);

    // go and stop together: only 'S'
    drive(1'b0, 1'b1, 1'b1);
    idle(150);
    @(negedge clk);
    check("link_after_both", bus.link_active, 0);

    // stop arriving during a 'G' frame
    drive(1'b0, 1'b1, 1'b0);
    idle(9);
    drive(1'b0, 1'b0, 1'b1);
    idle(100);

    // reset in the middle of a frame with stop pending
    drive(1'b0, 1'b1, 1'b0);
    idle(9);
    drive(1'b0, 1'b0, 1'b1);
    idle(9);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("midrst_tx", bus.TX, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_link", bus.link_active, 0);
    bad = 0;
    repeat (200) begin
      drive(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (bus.TX !== 1'b1 || bus.tx_done !== 1'b0) bad++;
    end
    check("midrst_quiet", bad, 0);

    // randomized request traffic
    repeat (60) begin
      idle($urandom_range(0, 60));
      case ($urandom_range(0, 3))
        0: drive(1'b0, 1'b1, 1'b0);
        1: drive(1'b0, 1'b0, 1'b1);
        2: drive(1'b0, 1'b1, 1'b1);
        default: begin
          drive(1'b0, 1'b1, 1'b0);
          drive(1'b0, 1'b1, 1'b0);
        end
      endcase
    end
    idle(100);

    // keep-alive behaviour after a 'G'
    drive(1'b0, 1'b1, 1'b0);
    idle(45);
`ifdef AUTH_TX_HEARTBEAT_EN
    f0 = frames_seen;
    idle(1000);
    check("heartbeat_frames", (frames_seen - f0) >= 6, 1);
`else
    bad = 0;
    repeat (1000) begin
      drive(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (bus.TX !== 1'b1) bad++;
    end
    check("no_heartbeat", bad, 0);
`endif

    n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 500) begin
      drive(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("drain_expected", exp_q.size(), 0);
    check("unexpected_frames", unexpected, 0);
    check("spurious_tx_done", spurious, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
